// File: rtl/activation_lut_loader_if.sv
// ---------------------------------------------------------------------------
// activation_lut_loader_if
// Byte-stream load channel for the activation LUT loader.
//   load_start : master -> slave, single-cycle (re)load request
//   wr_valid   : master -> slave, stream byte valid
//   wr_data    : master -> slave, stream byte (17 entries, then checksum)
//   wr_ready   : slave -> master, loader accepts a byte this cycle
// ---------------------------------------------------------------------------
interface activation_lut_loader_if;
    localparam int unsigned DW = 8;

    logic          load_start;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;

    modport master (
        output load_start,
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  load_start,
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/activation_lut_loader.sv
// ---------------------------------------------------------------------------
// activation_lut_loader
// Writer side of the piecewise-linear activation LUT. A 17-entry table plus
// an 8-bit additive checksum arrives as a byte stream into a shadow bank; a
// verified table is copied atomically into the active bank, which feeds the
// interpolator read ports. The old table stays readable during a reload.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   wr_if          : load channel (load_start, wr_valid, wr_data, wr_ready)
//   i_addr         : read index (upper nibble of z_value)
//   o_base         : active[addr], combinational
//   o_next_data    : active[addr+1], combinational, no wrap
//   o_lut_ready    : active bank holds a verified table
//   o_load_done    : one-cycle pulse on commit
//   o_load_error   : sticky checksum mismatch of the last load
// ---------------------------------------------------------------------------
module activation_lut_loader #(
    parameter int unsigned ENTRIES = 17,
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    activation_lut_loader_if.slave  wr_if,
    input  logic [AW-1:0]           i_addr,
    output logic [DW-1:0]           o_base,
    output logic [DW-1:0]           o_next_data,
    output logic                    o_lut_ready,
    output logic                    o_load_done,
    output logic                    o_load_error
);
    // Counter / index width: holds 0..ENTRIES (the checksum slot)
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [DW-1:0]   r_sum;
    logic [DW-1:0]   w_sum_nxt;
    logic            r_wr_ready;
    logic            r_lut_ready;
    logic            r_load_done;
    logic            r_load_error;
    logic            w_err_nxt;
    logic            w_shadow_we;
    logic            w_commit;
    logic            w_xfer;
    logic [CW-1:0]   w_rd_idx;
    logic [CW-1:0]   w_rd_idx_nxt;

    logic [DW-1:0]   r_shadow [ENTRIES];
    logic [DW-1:0]   r_active [ENTRIES];

    assign w_xfer = wr_if.wr_valid && r_wr_ready;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sum_nxt   = r_sum;
        w_err_nxt   = r_load_error;
        w_shadow_we = 1'b0;
        w_commit    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (wr_if.load_start) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                    w_sum_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_LOAD: begin
                // A restart wins over any byte offered in the same cycle
                if (wr_if.load_start) begin
                    w_cnt_nxt = '0;
                    w_sum_nxt = '0;
                end else if (w_xfer) begin
                    if (r_cnt == CW'(ENTRIES)) begin
                        if (wr_if.wr_data == r_sum) begin
                            w_state_nxt = S_COMMIT;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_err_nxt   = 1'b1;
                        end
                    end else begin
                        w_shadow_we = 1'b1;
                        w_sum_nxt   = r_sum + wr_if.wr_data;
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control and status registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_sum        <= '0;
            r_wr_ready   <= 1'b0;
            r_lut_ready  <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_sum        <= w_sum_nxt;
            r_wr_ready   <= (w_state_nxt == S_LOAD);
            r_lut_ready  <= r_lut_ready | w_commit;
            r_load_done  <= w_commit;
            r_load_error <= w_err_nxt;
        end
    end

    // Shadow bank: filled by the stream
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_shadow_we) begin
            r_shadow[r_cnt] <= wr_if.wr_data;
        end
    end

    // Active bank: whole-table copy on commit only
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_active[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_active[i] <= r_shadow[i];
            end
        end
    end

    // Read path; addr+1 is formed in CW bits so addr=15 reaches entry 16
    assign w_rd_idx     = CW'(i_addr);
    assign w_rd_idx_nxt = w_rd_idx + CW'(1);
    assign o_base       = r_active[w_rd_idx];
    assign o_next_data  = r_active[w_rd_idx_nxt];

    assign wr_if.wr_ready = r_wr_ready;
    assign o_lut_ready    = r_lut_ready;
    assign o_load_done    = r_load_done;
    assign o_load_error   = r_load_error;
endmodule

// File: doc/activation_lut_loader.md
# activation_lut_loader

Writer side of the activation-function lookup table. It receives a 17-entry piecewise-linear activation table as a byte stream and checks it with an 8-bit checksum. It commits the table atomically into an active bank that drives the `base`/`next_data` read ports feeding the interpolator. Shadow/active double buffering lets the neuron layer keep evaluating the old activation while a new table loads.

## Interface
- `ENTRIES`, 17: table depth. Fixed at 2^4+1 so that `addr`=15 has a valid `next_data`.
- `DW`, 8: entry and stream byte width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  single-cycle request to begin a (re)load.
- `wr_valid`  in  1  stream byte valid.
- `wr_data`  in  8  stream byte: entries 0..16 in order, then the checksum byte.
- `wr_ready`  out  1  loader accepts a byte.
- `addr`  in  4  read index, the upper nibble of z_value.
- `base`  out  8  active[addr], combinational from the active bank.
- `next_data`  out  8  active[addr+1], combinational; addr+1 is computed in 5 bits, with no wrap.
- `lut_ready`  out  1  active bank holds a verified table.
- `load_done`  out  1  one-cycle pulse: commit happened.
- `load_error`  out  1  sticky: checksum mismatch on the last load.

## Operation
- Storage: shadow[0..16] and active[0..16], 8 bits each. Only the loader writes shadow. Active is written only in COMMIT.
- States: IDLE, LOAD, COMMIT.
- IDLE:
  - `wr_ready`=0.
  - `load_start`=1: go to LOAD, cnt<=0, sum<=0, `load_error`<=0.
- LOAD:
  - `wr_ready`=1.
  - A transfer occurs when `wr_valid` && `wr_ready`.
  - For cnt 0..16: shadow[cnt]<=`wr_data`, sum<=sum+`wr_data` (mod 256), cnt<=cnt+1.
  - For cnt=17 (checksum byte): if `wr_data`==sum, go to COMMIT. Otherwise go to IDLE with `load_error`<=1; shadow is discarded and active is untouched.
  - With no transfer, state holds; there is no timeout.
- COMMIT:
  - `wr_ready`=0.
  - At the edge: active<=shadow (all 17 entries), `lut_ready`<=1, `load_done`<=1 for exactly one cycle, then go to IDLE.
- Read path: `base`/`next_data` always reflect the active bank, including during LOAD. `lut_ready` is never cleared by a reload or an error; only `rst` clears it.
- `load_start` in LOAD restarts the load: cnt<=0, sum<=0, and any transfer in that cycle is ignored. `load_start` in COMMIT is ignored.
- Arithmetic: sum is 8-bit with wrap-around. cnt is 5-bit and ranges 0..17.

## Timing
- Reset values: `wr_ready`=0, `lut_ready`=0, `load_done`=0, `load_error`=0, state=IDLE, cnt=0, sum=0.
- Reset values of storage: all shadow and active entries are 0, so `base`=`next_data`=0 for every `addr`.
- `rst` asserted mid-load or in COMMIT: immediate return to the reset state. Both banks clear and no partial commit occurs.
- `load_start` sampled at edge E: `wr_ready`=1 in the cycle after E. The earliest first byte transfer is at edge E+1.
- Throughput: one byte per cycle. A full load takes 18 transfer cycles, then 1 COMMIT cycle.
- Checksum accepted at edge C: state is COMMIT during cycle C..C+1. At edge C+1 active updates, `load_done`=1 and `lut_ready`=1. New `base`/`next_data` are visible after C+1.
- `load_error` asserts in the cycle after the bad checksum edge and holds until the next accepted `load_start` or `rst`.
- `addr` to `base`/`next_data`: combinational, zero cycles.

## Test plan
- Reset then read every addr: `base`=`next_data`=0, `lut_ready`=0, `wr_ready`=0.
- Load entries i*15 (0,15,…,240) plus checksum 248 back-to-back:
  - `load_done` pulses once, 1 cycle after the checksum transfer edge; `lut_ready`=1.
  - addr=3 gives 45/60; addr=15 gives 225/240.
- Same stream with checksum 247: `load_error`=1, `lut_ready` unchanged, active still holds the prior table, no `load_done`.
- Random `wr_valid` gaps during a valid load: same final table.
  - While loading a second table, addr=3 still reads 45/60 until the commit edge, then the new values.
- `load_start` after 9 bytes, then a full new load: only the new table commits; the 9 stale bytes do not affect the checksum.
- `rst` asserted in the COMMIT cycle: all outputs and the active bank return to 0, and `lut_ready`=0.
